fifo_rd_adapter: RTL and testbench



---
 rtl/fifo_rd_adapter.sv | 84 ++++++++
 tb/tb_fifo_rd_adapter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_adapter.sv
// Read-side adapter for the router input FIFO: turns the pop/one-cycle-latency
// read interface into a registered valid/ready flit stream through a 2-entry buffer.
module fifo_rd_adapter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             REMPTY,
  input  logic [WIDTH-1:0] RDATA,
  output logic             RINC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       OCC
);

  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic             xfer;
  logic [2:0]       committed;

  assign OUT_VALID = (occ_q != 2'd0);
  assign OUT_DATA  = buf_q[head_q];
  assign OCC       = occ_q;
  assign xfer      = OUT_VALID & OUT_READY;

  // Entries held or already popped, after this cycle's transfer; never negative
  // because a transfer implies at least one buffered entry.
  assign committed = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, xfer};

  // OUT_READY feeds RINC combinationally so a slot freed this cycle can be refilled.
  assign RINC = RSTn & ~REMPTY & (committed <= 3'd1);

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    tail_d   = tail_q;
    head_d   = head_q;
    if (inflight_q) begin
      buf_d[tail_q] = RDATA;
      tail_d        = tail_q + 1'b1;
    end
    if (xfer) begin
      head_d = head_q + 1'b1;
    end
    occ_d = committed[1:0];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= RINC;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
    end
  end

  // The buffer can never be asked to hold more than two flits.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      assert ({1'b0, occ_q} + {2'b0, inflight_q} <= 3'd2);
    end
  end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter with a behavioural read-side FIFO model.
module tb_fifo_rd_adapter;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         REMPTY;
  logic [W-1:0] RDATA = '0;
  logic         RINC;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] OUT_DATA;
  logic [1:0]   OCC;

  logic [W-1:0] fmem [256];
  logic [7:0]   fwr = 8'd0;
  logic [7:0]   frd = 8'd0;

  int checks = 0;
  int errors = 0;
  int pops;
  int got;

  always #5 CLK = ~CLK;

  assign REMPTY = (frd == fwr);

  // FIFO read side: data appears the cycle after an accepted pop; shares RSTn.
  always @(posedge CLK) begin
    if (!RSTn) begin
      frd <= fwr;
    end else if (RINC && !REMPTY) begin
      RDATA <= fmem[frd];
      frd   <= frd + 8'd1;
    end
  end

  fifo_rd_adapter #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .REMPTY    (REMPTY),
    .RDATA     (RDATA),
    .RINC      (RINC),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OCC       (OCC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [W-1:0] d);
    fmem[fwr] = d;
    fwr = fwr + 8'd1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rinc"}, 32'(RINC), 32'd0);
    chk({tag, "_vld"},  32'(OUT_VALID), 32'd0);
    chk({tag, "_occ"},  32'(OCC), 32'd0);
  endtask

  initial begin
    RSTn      = 1'b0;
    OUT_READY = 1'b1;

    // Reset and idle
    tick();
    tick();
    settle();
    chk_idle("rst");
    chk("rst_data", 32'(OUT_DATA), 32'd0);
    tick();
    RSTn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      settle();
      chk_idle("idle");
      chk("idle_data", 32'(OUT_DATA), 32'd0);
    end

    // Single flit
    tick();
    push(8'hA5);
    settle();
    chk("single_c0_rinc", 32'(RINC), 32'd1);
    chk("single_c0_vld", 32'(OUT_VALID), 32'd0);
    tick();
    settle();
    chk_idle("single_c1");
    tick();
    settle();
    chk("single_c2_vld", 32'(OUT_VALID), 32'd1);
    chk("single_c2_data", 32'(OUT_DATA), 32'hA5);
    chk("single_c2_occ", 32'(OCC), 32'd1);
    chk("single_c2_rinc", 32'(RINC), 32'd0);
    tick();
    settle();
    chk_idle("single_c3");

    // Streaming 0x01..0x10
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) for (int i = 1; i <= 16; i++) push(8'(i));
      settle();
      chk("stream_rinc", 32'(RINC), (c < 16) ? 32'd1 : 32'd0);
      chk("stream_vld", 32'(OUT_VALID), (c >= 2 && c < 18) ? 32'd1 : 32'd0);
      if (c >= 2 && c < 18) chk("stream_data", 32'(OUT_DATA), 32'(c - 1));
    end

    // Backpressure 0x10..0x15, released in cycle 8
    pops = 0;
    got  = 0;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c == 0) begin
        OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
      end
      if (c == 8) OUT_READY = 1'b1;
      settle();
      if (c < 8 && RINC) pops++;
      if (c == 3) chk("bp_occ_c3", 32'(OCC), 32'd2);
      if (c >= 2 && c < 8) begin
        chk("bp_hold_vld", 32'(OUT_VALID), 32'd1);
        chk("bp_hold_data", 32'(OUT_DATA), 32'h10);
      end
      if (OUT_VALID && OUT_READY) begin
        chk("bp_order", 32'(OUT_DATA), 32'(8'h10 + got));
        got++;
      end
    end
    chk("bp_pops_before_release", 32'(pops), 32'd2);
    chk("bp_delivered", 32'(got), 32'd6);
    chk("bp_final_occ", 32'(OCC), 32'd0);

    // Alternating OUT_READY, 8 flits 0x20..0x27
    got = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 0) for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
      OUT_READY = (c % 2 == 0);
      settle();
      if (OUT_VALID && OUT_READY) begin
        chk("alt_order", 32'(OUT_DATA), 32'(8'h20 + got));
        got++;
      end
    end
    chk("alt_delivered", 32'(got), 32'd8);

    // Reset while the buffer is full and the FIFO still holds data
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) begin
        OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
      end
      settle();
    end
    chk("mrst_pre_occ", 32'(OCC), 32'd2);
    chk("mrst_pre_empty", 32'(REMPTY), 32'd0);
    #2;
    RSTn = 1'b0;
    #1;
    chk_idle("mrst_during");
    chk("mrst_data", 32'(OUT_DATA), 32'd0);
    tick();
    tick();
    RSTn      = 1'b1;
    OUT_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      settle();
      chk_idle("mrst_after");
    end
    tick();
    push(8'h40);
    settle();
    chk("mrst_new_c0_rinc", 32'(RINC), 32'd1);
    tick();
    settle();
    chk("mrst_new_c1_vld", 32'(OUT_VALID), 32'd0);
    tick();
    settle();
    chk("mrst_new_c2_vld", 32'(OUT_VALID), 32'd1);
    chk("mrst_new_c2_data", 32'(OUT_DATA), 32'h40);
    tick();
    settle();
    chk_idle("mrst_new_c3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
